prime_streamer: RTL
===================

// Module: prime_streamer
// PURPOSE
//   Downstream sequencer for the prime generator. Issues go pulses and captures each
//   result into a small FIFO. Emits primes on a valid/ready stream until a requested
//   count is delivered. Sits between primogen and any consumer (UART, display, checker).
// PARAMETERS
//   WIDTH_LOG       4   prime width is 1<<WIDTH_LOG bits; must match the generator
//   FIFO_DEPTH_LOG  2   output FIFO holds 1<<FIFO_DEPTH_LOG entries
//   CNT_WIDTH       16  width of the requested-count input and internal counters
// PORTS
//   clk        in   1          clock; all state updates on posedge
//   rst        in   1          synchronous reset, active-high
//   start      in   1          begin a run; sampled only when busy=0
//   num        in   CNT_WIDTH  number of primes to deliver; latched on start
//   busy       out  1          run in progress
//   done       out  1          1-cycle pulse when the num-th prime is accepted downstream
//   error      out  1          sticky; generator reported overflow (or check failure)
//   gen_go     out  1          to generator go; registered 1-cycle pulse
//   gen_ready  in   1          from generator ready
//   gen_error  in   1          from generator error
//   gen_res    in   1<<WIDTH_LOG  from generator res
//   out_valid  out  1          FIFO non-empty
//   out_ready  in   1          consumer accepts out_data when out_valid&&out_ready
//   out_data   out  1<<WIDTH_LOG  FIFO head
// BEHAVIOUR
//   Reset: busy=0, done=0, error=0, gen_go=0, out_valid=0, out_data=0, FIFO empty,
//     counters 0, state IDLE. rst clears a run in flight; the generator must be reset in
//     the same cycle. The first emitted prime after a joint reset is 2; the generator's
//     initial res=1 is never emitted.
//   States:
//     IDLE:  start&&!error -> num==0 ? pulse done next cycle, stay IDLE : ISSUE, busy=1.
//            start while busy or while error=1 is ignored.
//     ISSUE: if issued<num and FIFO occupancy<depth: gen_go<=1, issued++, -> GO_HOLD;
//            else if issued==num: -> DRAIN.
//     GO_HOLD: gen_go=1 this cycle; gen_ready is stale and ignored; gen_go<=0; -> WAIT.
//     WAIT:  hold until gen_ready=1. gen_error=1: error<=1, no push, -> IDLE, busy<=0.
//            Otherwise push gen_res into FIFO -> ISSUE.
//     DRAIN: wait until popped==num; on that pop, done=1 for 1 cycle -> IDLE, busy<=0.
//   Only one request is ever outstanding, so the occupancy check in ISSUE guarantees
//     the WAIT push never overflows.
//   Pop counter increments on each out_valid&&out_ready. done fires on the cycle after
//     the pop that makes popped==num, also when that pop happens in ISSUE or WAIT.
//   Push and pop in the same cycle: occupancy unchanged; pop of the entry being pushed
//     is impossible (push becomes visible the next cycle).
//   Latency: a capture in WAIT drives out_valid=1 on the next cycle when the FIFO was
//     empty. FIFO pointers wrap modulo depth. Occupancy counter is FIFO_DEPTH_LOG+1 bits.
//   After error: FIFO entries still drain; done never fires for that run; error clears
//     only on rst. The generator stays in overflow, so a restart is useless.
//   Runs do not restart the sequence: a new run continues from the generator's last prime.
//   out_data is undefined-free: it holds the last head value when the FIFO is empty.
// CONFIGURATION
//   PRIME_STREAMER_CHECK_EN defined: keeps last_pushed (reset 0). In WAIT, gen_res<=
//     last_pushed sets error=1, drops the value, -> IDLE (monotonicity check).
//   Not defined: no last_pushed register, no comparison; gen_res is pushed unchecked.
// TESTING (bench instantiates primogen with the SIM reduced table)
//   1 rst; start num=5, out_ready=1 -> out_data 2,3,5,7,11; exactly 5 gen_go pulses;
//     one done pulse after the 11 pop.
//   2 out_ready=0, start num=10, depth 4 -> 4 gen_go pulses then stall with out_valid=1.
//     Raise out_ready -> 2..29 in order, done once.
//   3 start num=0 -> done 1 cycle later, gen_go never asserted, out_valid stays 0.
//   4 start while busy ignored (num unchanged); after done, start num=2 -> 13,17 (continues).
//   5 WIDTH_LOG=3, start num=60 -> 54 primes 2..251, then error=1, no done.
//     FIFO drains fully; later start ignored.
//   6 rst asserted mid-run with 2 entries queued -> next cycle out_valid=0, busy=0,
//     error=0; new start num=1 -> 2.

Source files
------------

// File: rtl/prime_streamer.sv
// prime_streamer: sequences go/ready requests to the prime generator, buffers results in a FIFO and streams num primes
// Define PRIME_STREAMER_CHECK_EN to reject any generator result not above the last pushed prime.
module prime_streamer #(
  parameter int WIDTH_LOG      = 4,
  parameter int FIFO_DEPTH_LOG = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      num,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      gen_go,
  input  logic                      gen_ready,
  input  logic                      gen_error,
  input  logic [(1<<WIDTH_LOG)-1:0] gen_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<WIDTH_LOG)-1:0] out_data
);
  localparam int W = 1 << WIDTH_LOG;
  localparam int D = 1 << FIFO_DEPTH_LOG;
  typedef enum logic [2:0] {IDLE, ISSUE, GO_HOLD, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d, gen_go_q, gen_go_d;
  logic [CNT_WIDTH-1:0] num_q, num_d, issued_q, issued_d, popped_q, popped_d;
  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];
  logic [W-1:0] hold_q, hold_d;
  logic [FIFO_DEPTH_LOG-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_DEPTH_LOG:0] cnt_q, cnt_d;
  logic push, pop, final_pop, bad_res;
`ifdef PRIME_STREAMER_CHECK_EN
  logic [W-1:0] last_q, last_d;
  assign bad_res = gen_res <= last_q;
`else
  assign bad_res = 1'b0;
`endif
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign gen_go    = gen_go_q;
  assign out_valid = cnt_q != '0;
  // hold_q keeps the last popped head so out_data is stable while empty
  assign out_data  = out_valid ? mem_q[rd_q] : hold_q;
  assign pop       = out_valid && out_ready;
  assign final_pop = busy_q && pop && (popped_q + 1'b1 == num_q);
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    gen_go_d = 1'b0;
    num_d    = num_q;
    issued_d = issued_q;
    popped_d = pop ? popped_q + 1'b1 : popped_q;
    push     = 1'b0;
    case (state_q)
      IDLE: if (start && !error_q) begin
        num_d    = num;
        issued_d = '0;
        popped_d = '0;
        done_d   = num == '0;
        state_d  = num == '0 ? IDLE : ISSUE;
        busy_d   = num != '0;
      end
      ISSUE: if (issued_q != num_q && !cnt_q[FIFO_DEPTH_LOG]) begin
        gen_go_d = 1'b1;
        issued_d = issued_q + 1'b1;
        state_d  = GO_HOLD;
      end else if (issued_q == num_q) begin
        state_d = DRAIN;
      end
      GO_HOLD: state_d = WAIT;
      WAIT: if (gen_ready) begin
        error_d = gen_error || bad_res;
        push    = !(gen_error || bad_res);
        busy_d  = !(gen_error || bad_res);
        state_d = (gen_error || bad_res) ? IDLE : ISSUE;
      end
      DRAIN: state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (final_pop) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
    mem_d = mem_q;
    if (push) mem_d[wr_q] = gen_res;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    cnt_d  = push ? (pop ? cnt_q : cnt_q + 1'b1) : (pop ? cnt_q - 1'b1 : cnt_q);
    hold_d = pop ? mem_q[rd_q] : hold_q;
  end
`ifdef PRIME_STREAMER_CHECK_EN
  assign last_d = push ? gen_res : last_q;
  always_ff @(posedge clk) last_q <= rst ? '0 : last_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      gen_go_q <= 1'b0;
      num_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      mem_q    <= '{default: '0};
      hold_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      gen_go_q <= gen_go_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      mem_q    <= mem_d;
      hold_q   <= hold_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
